mem_access_ctrl: RTL and testbench

//  Sequences LW/SW requests from the execute stage onto a single-port data-memory bus with req/ack handshake.

---
 rtl/mem_access_ctrl_pkg.sv | 20 ++
 rtl/mem_access_ctrl_timeout_cnt.sv | 29 ++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Holds the FSM state encoding, bus-width defaults and the alignment helper.
package mem_access_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int RD_W        = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Only whole-word accesses are supported.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Wait-cycle counter for an outstanding bus access.
// Flags expiry once TIMEOUT cycles have elapsed without a clear.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences word loads/stores from exe onto a req/ack data-memory bus,
// stalling the pipeline while busy and pulsing writeback or error.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [RD_W-1:0]   rd,
    input  logic              clr,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [RD_W-1:0]   rd_q;
    logic              wb_en_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              err_q;

    logic is_idle;
    logic is_busy;
    logic req_live;
    logic accept;
    logic reject;
    logic expired;

    assign is_idle  = (state_q == ST_IDLE);
    assign is_busy  = (state_q == ST_BUSY);
    assign req_live = (load_en | store_en) & ~clr;
    assign accept   = is_idle & (load_en ^ store_en) & ~clr & word_aligned(addr[1:0]);
    // Any live request that is not accepted is either dual-issued or misaligned.
    assign reject   = is_idle & req_live & ~accept;
    assign stall    = accept | (is_busy & ~mem_ack);

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (is_idle | mem_ack | expired),
        .en      (is_busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_q        <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= store_en;
                        mem_addr_q  <= addr;
                        mem_wdata_q <= data;
                        rd_q        <= rd;
                    end else if (reject) begin
                        err_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // An ack in the last allowed cycle still completes normally.
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            wb_en_q   <= 1'b1;
                            wb_rd_q   <= rd_q;
                            wb_data_q <= mem_rdata;
                        end
                    end else if (expired) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model
// compared against the DUT every cycle, plus literal per-scenario expectations.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en, store_en, clr, mem_ack;
    logic [31:0] addr, data, mem_rdata;
    logic [4:0]  rd;
    logic        stall, mem_req, mem_we, wb_en, err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [4:0]  wb_rd;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en),
        .addr(addr), .data(data), .rd(rd), .clr(clr), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: an outstanding transaction plus the pulses it leaves behind.
    bit          m_busy;
    int          m_waited;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    bit          e_wb_en, e_err;
    logic [4:0]  e_wb_rd;
    logic [31:0] e_wb_data;

    // Observations gathered per scenario.
    int req_cnt, wb_cnt, err_cnt, we_cnt;
    int wb_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
        e_wb_en = 0; e_err = 0; e_wb_rd = 0; e_wb_data = 0;
    endtask

    task automatic clear_obs();
        req_cnt = 0; wb_cnt = 0; err_cnt = 0; we_cnt = 0;
        wb_cyc.delete();
    endtask

    task automatic drive(input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r, input bit c,
                         input bit ack, input logic [31:0] rdat);
        load_en = ld; store_en = st; addr = a; data = d; rd = r; clr = c;
        mem_ack = ack; mem_rdata = rdat;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    endtask

    // One clock: compare at the falling edge, then advance the model to the next rising edge.
    task automatic step();
        bit want_stall, acc;
        @(negedge clk);
        acc = !m_busy && (load_en ^ store_en) && !clr && (addr % 4 == 0);
        want_stall = rst && (acc || (m_busy && !mem_ack));
        chk("stall",   stall,   want_stall);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_we",    mem_we,    m_we);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("wb_en",   wb_en,   e_wb_en);
        chk("err",     err,     e_err);
        chk("wb_rd",   wb_rd,   e_wb_rd);
        chk("wb_data", wb_data, e_wb_data);
        if (mem_req) req_cnt++;
        if (mem_req && mem_we) we_cnt++;
        if (wb_en) begin wb_cnt++; wb_cyc.push_back(cyc); end
        if (err) err_cnt++;

        e_wb_en = 0;
        e_err   = 0;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if ((load_en || store_en) && !clr) begin
                if ((load_en && store_en) || (addr % 4 != 0)) begin
                    e_err = 1;
                end else begin
                    m_busy = 1; m_waited = 0; m_we = store_en;
                    m_addr = addr; m_wdata = data; m_rd = rd;
                end
            end
        end else if (mem_ack) begin
            m_busy = 0;
            if (!m_we) begin
                e_wb_en = 1; e_wb_rd = m_rd; e_wb_data = mem_rdata;
            end
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                m_busy = 0; e_err = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_en",   wb_en,   0);
        chk("rst_err",     err,     0);
        chk("rst_addr",    mem_addr, 0);
        step(); step();
        rst = 1'b1;

        // 1: load, ack on the third bus cycle
        clear_obs();
        drive(1, 0, 32'h100, 32'h0, 5'd5, 0, 0, 32'h0); step();
        idle(); step(); step();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hDEADBEEF); step();
        idle(); step(); step();
        chk("t1_req_cycles", req_cnt, 3);
        chk("t1_wb_pulses",  wb_cnt,  1);
        chk("t1_wb_rd",      wb_rd,   5);
        chk("t1_wb_data",    wb_data, 32'hDEADBEEF);
        $display("load 0x100 rd=5: req_cycles=%0d wb=%0d data=%h", req_cnt, wb_cnt, wb_data);

        // 2: store, ack next cycle
        clear_obs();
        drive(0, 1, 32'h204, 32'h12345678, 5'd3, 0, 0, 32'h0); step();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hFFFF0000); step();
        idle(); step(); step();
        chk("t2_req_cycles", req_cnt, 1);
        chk("t2_we_cycles",  we_cnt,  1);
        chk("t2_no_wb",      wb_cnt,  0);
        $display("store 0x204: req_cycles=%0d wb=%0d", req_cnt, wb_cnt);

        // 3: misaligned and dual-issue errors
        clear_obs();
        drive(1, 0, 32'h102, 32'h0, 5'd1, 0, 0, 32'h0); step();
        idle(); step(); step();
        drive(1, 1, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0); step();
        idle(); step(); step();
        chk("t3_err_pulses", err_cnt, 2);
        chk("t3_no_req",     req_cnt, 0);
        $display("errors: err_pulses=%0d req_cycles=%0d", err_cnt, req_cnt);

        // 4a: timeout with no ack
        clear_obs();
        drive(1, 0, 32'h300, 32'h0, 5'd9, 0, 0, 32'h0); step();
        idle();
        for (int i = 0; i < TO + 2; i++) step();
        chk("t4a_req_cycles", req_cnt, 16);
        chk("t4a_err_pulses", err_cnt, 1);
        chk("t4a_no_wb",      wb_cnt,  0);
        $display("timeout: req_cycles=%0d err=%0d", req_cnt, err_cnt);

        // 4b: ack in the final allowed cycle beats the timeout
        clear_obs();
        drive(1, 0, 32'h304, 32'h0, 5'd10, 0, 0, 32'h0); step();
        idle();
        for (int i = 0; i < TO - 1; i++) step();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hA5A5A5A5); step();
        idle(); step(); step();
        chk("t4b_req_cycles", req_cnt, 16);
        chk("t4b_no_err",     err_cnt, 0);
        chk("t4b_wb_data",    wb_data, 32'hA5A5A5A5);
        $display("late ack: req_cycles=%0d err=%0d", req_cnt, err_cnt);

        // 5a: flushed load is dropped
        clear_obs();
        drive(1, 0, 32'h400, 32'h0, 5'd7, 1, 0, 32'h0); step();
        idle(); step(); step();
        chk("t5a_no_req", req_cnt, 0);
        chk("t5a_no_err", err_cnt, 0);
        $display("flushed load: req_cycles=%0d err=%0d", req_cnt, err_cnt);

        // 5b: back-to-back loads, second accepted right after the first ack
        clear_obs();
        drive(1, 0, 32'h400, 32'h0, 5'd7, 0, 0, 32'h0); step();
        drive(1, 0, 32'h999, 32'h0, 5'd2, 0, 1, 32'h11111111); step();
        drive(1, 0, 32'h404, 32'h0, 5'd8, 0, 0, 32'h0); step();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h22222222); step();
        idle(); step(); step();
        chk("t5b_wb_pulses", wb_cnt, 2);
        if (wb_cnt == 2) chk("t5b_wb_spacing", wb_cyc[1] - wb_cyc[0], 2);
        chk("t5b_wb_rd",   wb_rd,   8);
        chk("t5b_wb_data", wb_data, 32'h22222222);
        $display("back-to-back: wb=%0d last rd=%0d data=%h", wb_cnt, wb_rd, wb_data);

        // 6: asynchronous reset while an access is outstanding
        clear_obs();
        drive(1, 0, 32'h500, 32'h0, 5'd4, 0, 0, 32'h0); step();
        idle(); step();
        chk("t6_req_before", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("t6_async_req",   mem_req, 0);
        chk("t6_async_stall", stall,   0);
        chk("t6_async_addr",  mem_addr, 0);
        chk("t6_async_wbrd",  wb_rd,   0);
        model_reset();
        step();
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h33333333);
        step(); step();
        idle(); step();
        chk("t6_no_wb", wb_cnt, 0);
        $display("reset mid-busy: wb=%0d req=%0d", wb_cnt, mem_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
